// File: rtl/lc4_fetch_pkg.sv
// -----------------------------------------------------------------------------
// lc4_fetch_pkg
//   Shared definitions for the LC4 instruction fetch unit: PC width, the
//   default reset PC, the fetch FSM state encoding, the {pc, insn} buffer
//   entry type and a small PC increment helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package lc4_fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h8200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] insn;
  } fetch_entry_t;

  // Sequential PC; natural 16-bit overflow gives the FFFF -> 0000 wrap.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/lc4_fetch_buf.sv
// -----------------------------------------------------------------------------
// lc4_fetch_buf
//   Small {pc, insn} FIFO sitting between instruction memory and the decoder.
//   Flush has priority over push and pop and returns the FIFO to its reset
//   state (count and both pointers zero).
//
//   Ports
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_push           write i_push_entry at the tail
//     i_push_entry     {pc, insn} to write
//     i_pop            retire the head entry
//     i_flush          discard all contents
//     o_count          number of valid entries
//     o_valid          head holds an entry
//     o_head           head entry; all zero when o_valid = 0
// -----------------------------------------------------------------------------
module lc4_fetch_buf
  import lc4_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output fetch_entry_t     o_head
);

  // Storage needs no reset: the head is masked to zero whenever it is empty.
  fetch_entry_t     entry_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic pop_ok;
  logic push_ok;

  // A push into a full FIFO is only accepted when the same cycle pops.
  assign pop_ok  = i_pop & (count_q != '0);
  assign push_ok = i_push & ((count_q < CNT_W'(DEPTH)) | pop_ok);

  // Pointers rely on power-of-two wrap; DEPTH is 2 in practice.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) begin
      entry_mem[wr_ptr_q] <= i_push_entry;
    end
  end

  assign o_count = count_q;
  assign o_valid = (count_q != '0);
  assign o_head  = o_valid ? entry_mem[rd_ptr_q] : '0;

endmodule

// File: rtl/lc4_fetch.sv
// -----------------------------------------------------------------------------
// lc4_fetch
//   LC4 instruction fetch unit. Issues one instruction-memory read at a time,
//   buffers returned words with their PC in a 2-entry FIFO, and handles
//   control-flow redirects, including redirects that arrive while a read is
//   still outstanding (the late data is drained and dropped).
//
//   Ports
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     o_imem_req            read request (held until i_imem_ack)
//     o_imem_addr           read address, valid while o_imem_req = 1
//     i_imem_ack            single-cycle read completion
//     i_imem_data           read data, valid with i_imem_ack
//     o_insn_valid          buffer head holds an instruction
//     o_insn, o_pc          head instruction and its PC (0 when not valid)
//     i_insn_ready          consumer takes the head this cycle
//     i_redirect            control-flow change; flushes the buffer
//     i_redirect_pc         new fetch PC, sampled with i_redirect
// -----------------------------------------------------------------------------
module lc4_fetch
  import lc4_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [PC_W-1:0] i_imem_data,
  output logic            o_insn_valid,
  output logic [PC_W-1:0] o_insn,
  output logic [PC_W-1:0] o_pc,
  input  logic            i_insn_ready,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e    state_q,      state_d;
  logic [PC_W-1:0] fetch_pc_q,   fetch_pc_d;
  // Address of the read still in flight while draining after a redirect;
  // fetch_pc already holds the redirect target by then.
  logic [PC_W-1:0] drain_addr_q, drain_addr_d;

  logic             buf_push;
  logic             buf_pop;
  logic             buf_valid;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     push_entry;
  logic [CNT_W:0]   occ_after_ack;

  // A redirect discards the pop along with the buffer contents.
  assign buf_pop    = buf_valid & i_insn_ready & ~i_redirect;
  assign push_entry = {fetch_pc_q, i_imem_data};

  assign occ_after_ack = (CNT_W + 1)'(buf_count) + (CNT_W + 1)'(1)
                         - (CNT_W + 1)'(buf_pop);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    buf_push     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (i_redirect) fetch_pc_d = i_redirect_pc;
      end

      ST_FETCH: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
          if (i_imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            // Read still outstanding: keep presenting it until it returns.
            drain_addr_d = fetch_pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (i_imem_ack) begin
          buf_push   = 1'b1;
          fetch_pc_d = pc_next(fetch_pc_q);
          state_d    = (occ_after_ack > (CNT_W + 1)'(BUF_DEPTH - 1)) ? ST_HOLD
                                                                      : ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
          state_d    = ST_FETCH;
        end else if (buf_pop) begin
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (i_redirect) fetch_pc_d = i_redirect_pc;
        if (i_imem_ack) state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Request outputs are decoded from state only, so reset drops them at once.
  assign o_imem_req = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  always_comb begin
    o_imem_addr = '0;
    if (state_q == ST_FETCH)      o_imem_addr = fetch_pc_q;
    else if (state_q == ST_DRAIN) o_imem_addr = drain_addr_q;
  end

  lc4_fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (buf_push),
    .i_push_entry (push_entry),
    .i_pop        (buf_pop),
    .i_flush      (i_redirect),
    .o_count      (buf_count),
    .o_valid      (buf_valid),
    .o_head       (buf_head)
  );

  assign o_insn_valid = buf_valid;
  assign o_insn       = buf_head.insn;
  assign o_pc         = buf_head.pc;

endmodule

// File: tb/tb_lc4_fetch.sv
// -----------------------------------------------------------------------------
// tb_lc4_fetch
//   Directed bench for lc4_fetch. Instance dut uses the default reset PC,
//   instance dut_b uses RESET_PC = 16'hFFFF to exercise PC wrap.
//   Inputs change on the falling edge; outputs are checked on the falling edge
//   (or 1 ns after an asynchronous reset change).
// -----------------------------------------------------------------------------
module tb_lc4_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        insn_valid;
  logic [15:0] insn;
  logic [15:0] pc;
  logic        insn_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        rst_n_b;
  logic        imem_req_b;
  logic [15:0] imem_addr_b;
  logic        imem_ack_b;
  logic [15:0] imem_data_b;
  logic        insn_valid_b;
  logic [15:0] insn_b;
  logic [15:0] pc_b;
  logic        insn_ready_b;

  int n_checks;
  int n_fail;

  lc4_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_data   (imem_data),
    .o_insn_valid  (insn_valid),
    .o_insn        (insn),
    .o_pc          (pc),
    .i_insn_ready  (insn_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  lc4_fetch #(
    .RESET_PC(16'hFFFF)
  ) dut_b (
    .i_clk         (clk),
    .i_rst_n       (rst_n_b),
    .o_imem_req    (imem_req_b),
    .o_imem_addr   (imem_addr_b),
    .i_imem_ack    (imem_ack_b),
    .i_imem_data   (imem_data_b),
    .o_insn_valid  (insn_valid_b),
    .o_insn        (insn_b),
    .o_pc          (pc_b),
    .i_insn_ready  (insn_ready_b),
    .i_redirect    (1'b0),
    .i_redirect_pc (16'h0000)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic chk_req(input string tag, input logic exp_req, input logic [15:0] exp_addr);
    check({tag, ".req"}, 16'(imem_req), 16'(exp_req));
    if (exp_req) check({tag, ".addr"}, imem_addr, exp_addr);
  endtask

  task automatic chk_head(input string tag, input logic exp_valid,
                          input logic [15:0] exp_pc, input logic [15:0] exp_insn);
    check({tag, ".valid"}, 16'(insn_valid), 16'(exp_valid));
    check({tag, ".pc"},    pc,   exp_pc);
    check({tag, ".insn"},  insn, exp_insn);
  endtask

  task automatic drv(input logic ack, input logic [15:0] data, input logic ready,
                     input logic redir, input logic [15:0] rpc);
    imem_ack    = ack;
    imem_data   = data;
    insn_ready  = ready;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  // Reset, release, and step into the first FETCH cycle.
  task automatic do_reset(input string tag);
    drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_req({tag, ".first"}, 1'b1, 16'h8200);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    rst_n_b      = 1'b0;
    imem_ack_b   = 1'b0;
    imem_data_b  = 16'h0;
    insn_ready_b = 1'b0;
    drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Reset state: everything zero.
    @(negedge clk);
    chk_req("rst", 1'b0, 16'h0);
    check("rst.addr", imem_addr, 16'h0000);
    chk_head("rst", 1'b0, 16'h0, 16'h0);

    // T1: in-order fetch with immediate acks and a ready consumer.
    rst_n = 1'b1;
    #1 chk_req("t1.idle", 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t1.f0", 1'b1, 16'h8200);
    chk_head("t1.empty", 1'b0, 16'h0, 16'h0);
    drv(1'b1, mem_word(16'h8200), 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t1.f1", 1'b1, 16'h8201);
    chk_head("t1.h0", 1'b1, 16'h8200, mem_word(16'h8200));
    drv(1'b1, mem_word(16'h8201), 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t1.f2", 1'b1, 16'h8202);
    chk_head("t1.h1", 1'b1, 16'h8201, mem_word(16'h8201));
    drv(1'b1, mem_word(16'h8202), 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t1.f3", 1'b1, 16'h8203);
    chk_head("t1.h2", 1'b1, 16'h8202, mem_word(16'h8202));
    drv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_head("t1.drained", 1'b0, 16'h0, 16'h0);

    // T2: consumer stalled, buffer fills, HOLD, ack in HOLD ignored, pop resumes.
    do_reset("t2");
    drv(1'b1, mem_word(16'h8200), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t2.f1", 1'b1, 16'h8201);
    chk_head("t2.h0", 1'b1, 16'h8200, mem_word(16'h8200));
    drv(1'b1, mem_word(16'h8201), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t2.hold", 1'b0, 16'h0);
    chk_head("t2.hold", 1'b1, 16'h8200, mem_word(16'h8200));
    drv(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t2.hold_ack", 1'b0, 16'h0);
    drv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t2.resume", 1'b1, 16'h8202);
    chk_head("t2.h1", 1'b1, 16'h8201, mem_word(16'h8201));
    drv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk_head("t2.empty", 1'b0, 16'h0, 16'h0);

    // T3: redirect with a read outstanding; second redirect during drain wins.
    do_reset("t3");
    drv(1'b1, mem_word(16'h8200), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_head("t3.h0", 1'b1, 16'h8200, mem_word(16'h8200));
    drv(1'b0, 16'h0, 1'b0, 1'b1, 16'h0777);
    @(negedge clk);
    chk_req("t3.drain1", 1'b1, 16'h8201);
    chk_head("t3.flush", 1'b0, 16'h0, 16'h0);
    drv(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
    @(negedge clk);
    chk_req("t3.drain2", 1'b1, 16'h8201);
    drv(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t3.refetch", 1'b1, 16'h0040);
    chk_head("t3.no_stale", 1'b0, 16'h0, 16'h0);
    drv(1'b1, mem_word(16'h0040), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t3.f1", 1'b1, 16'h0041);
    chk_head("t3.h0040", 1'b1, 16'h0040, mem_word(16'h0040));

    // T4: redirect together with ack and pop.
    drv(1'b1, mem_word(16'h0041), 1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    chk_req("t4.redir", 1'b1, 16'h1234);
    chk_head("t4.flush", 1'b0, 16'h0, 16'h0);
    drv(1'b1, mem_word(16'h1234), 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t4.f1", 1'b1, 16'h1235);
    chk_head("t4.h1234", 1'b1, 16'h1234, mem_word(16'h1234));

    // T5: reset asserted mid-request.
    drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    #1 chk_req("t5.rst", 1'b0, 16'h0);
    check("t5.rst.addr", imem_addr, 16'h0000);
    chk_head("t5.rst", 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_req("t5.idle", 1'b0, 16'h0);
    @(negedge clk);
    chk_req("t5.first", 1'b1, 16'h8200);
    chk_head("t5.empty", 1'b0, 16'h0, 16'h0);

    // T6: RESET_PC = FFFF wraps to 0000.
    rst_n_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6.req", 16'(imem_req_b), 16'h0001);
    check("t6.addr0", imem_addr_b, 16'hFFFF);
    imem_ack_b  = 1'b1;
    imem_data_b = mem_word(16'hFFFF);
    @(negedge clk);
    check("t6.addr1", imem_addr_b, 16'h0000);
    check("t6.pc0", pc_b, 16'hFFFF);
    check("t6.insn0", insn_b, mem_word(16'hFFFF));
    imem_ack_b   = 1'b1;
    imem_data_b  = mem_word(16'h0000);
    insn_ready_b = 1'b1;
    @(negedge clk);
    check("t6.valid1", 16'(insn_valid_b), 16'h0001);
    check("t6.pc1", pc_b, 16'h0000);
    check("t6.insn1", insn_b, mem_word(16'h0000));
    check("t6.addr2", imem_addr_b, 16'h0001);
    imem_ack_b   = 1'b0;
    insn_ready_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc4_fetch.md
LC4_FETCH -- requirements
Module: lc4_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h8200, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 o_imem_req  output  1  instruction memory read request.
REQ-006 o_imem_addr  output  16  read address; valid while o_imem_req=1.
REQ-007 i_imem_ack  input  1  single-cycle read completion.
REQ-008 i_imem_data  input  16  instruction word; valid in the cycle where i_imem_ack=1.
REQ-009 o_insn_valid  output  1  buffer head holds an instruction.
REQ-010 o_insn  output  16  head instruction (the ALU i_insn); 0 when o_insn_valid=0.
REQ-011 o_pc  output  16  PC of the head instruction (the ALU i_pc); 0 when o_insn_valid=0.
REQ-012 i_insn_ready  input  1  consumer accepts the head; pop = o_insn_valid & i_insn_ready.
REQ-013 i_redirect  input  1  control-flow change (taken BR, JMP, JSR(R), TRAP, RTI).
REQ-014 i_redirect_pc  input  16  new PC (the ALU o_result); sampled when i_redirect=1.

Function
REQ-015 States: IDLE, FETCH, HOLD, DRAIN; encoding 2 bits.
REQ-016 IDLE: o_imem_req=0; goes to FETCH on the first clock edge after reset is released.
REQ-017 FETCH: o_imem_req=1 and o_imem_addr=fetch_pc, held stable until i_imem_ack; at most one request is outstanding.
REQ-018 On ack in FETCH without redirect: write {fetch_pc, i_imem_data} to the buffer, then set fetch_pc = fetch_pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-019 After an ack, stay in FETCH if next-cycle occupancy is at most 1, else go to HOLD; occupancy = count + ack - pop.
REQ-020 HOLD: o_imem_req=0; go to FETCH on the edge where a pop occurs.
REQ-021 Captured data appears at the buffer head, with o_insn_valid=1, in the cycle after the ack (1-cycle latency).
REQ-022 Simultaneous write and pop with count=2 is legal; occupancy stays 2.
REQ-023 Simultaneous write and pop with count=1 is legal; the head advances to the new entry.
REQ-024 Redirect flushes the buffer: count=0 and o_insn_valid=0 in the next cycle; fetch_pc = i_redirect_pc.
REQ-025 Redirect has priority over pop and over buffer write in the same cycle; both are discarded.
REQ-026 Redirect while a request is unacked: go to DRAIN.
REQ-027 DRAIN: o_imem_req and o_imem_addr stay at the old request until ack, then the returned data is discarded and the state goes to FETCH with the new fetch_pc.
REQ-028 Redirect in the same cycle as an ack: discard the data, go to FETCH with the new PC on the next cycle.
REQ-029 Redirect in HOLD or IDLE: go to FETCH with the new PC.
REQ-030 Redirect during DRAIN: overwrite the pending PC; the newest redirect wins.
REQ-031 i_imem_ack outside FETCH/DRAIN is ignored.

Reset
REQ-032 While i_rst_n=0: state IDLE, fetch_pc=RESET_PC, buffer count=0, pointers 0, all outputs 0.
REQ-033 Reset asserted mid-request abandons the request immediately; no data is captured; the memory side must tolerate the dropped request.

Structure
REQ-034 Shared package lc4_fetch_pkg holds the state encodings, RESET_PC default and PC width constant.
REQ-035 One sub-module lc4_fetch_buf, a 2-entry {pc, insn} FIFO with push, pop, flush, count and head outputs; the FSM and fetch_pc stay in lc4_fetch.

Verification
REQ-036 Reset release, ack each request after 1 cycle, ready=1 -> addresses 8200, 8201, 8202 in order; o_pc matches each; first o_insn_valid 1 cycle after first ack.
REQ-037 ready=0 with 2 acks -> HOLD, o_imem_req=0; one pop -> next request at 8202.
REQ-038 Redirect to 16'h0040 with a request unacked for 3 cycles -> addr held at old PC; acked data dropped; next request at 0040; no stale o_insn_valid.
REQ-039 Redirect to 16'h1234 in the same cycle as ack and pop -> buffer empty next cycle, pop ignored; next request at 1234.
REQ-040 RESET_PC=16'hFFFF -> second request at 0000 with o_pc=0000.
REQ-041 i_rst_n low mid-request -> o_imem_req=0 immediately; after release the first request is at RESET_PC.
